// File: rtl/rv32i_exec_datapath.sv
// RV32I execute-stage datapath: immediate decode, ALU, branch compare,
// plus the core clock pass-through and stretched core reset.
module rv32i_exec_datapath #(
  parameter int RESET_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        clk,
  output logic        resetn,
  input  logic [31:0] instr,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] imm,
  output logic [31:0] result,
  output logic        take_b
);

  localparam int CW = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(RESET_CYCLES - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ---------------- clock / reset conditioner ----------------
  // Power-up values keep the core in reset straight after configuration.
  logic [CW-1:0] cnt = '0;
  logic          rstn_q = 1'b0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      rstn_q <= 1'b0;
    end else if (cnt != LAST) begin
      cnt    <= cnt + CW'(1);
      rstn_q <= 1'b0;
    end else begin
      rstn_q <= 1'b1;
    end
  end

  assign clk    = CLK;
  assign resetn = rstn_q;

  // ---------------- decode fields ----------------
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       alt;
  logic       is_i;
  logic       is_s;
  logic       is_b;
  logic       is_u;
  logic       is_j;
  logic       is_r;
  logic       is_alui;

  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign alt     = instr[30];

  assign is_i    = (opcode == OP_LOAD) || (opcode == OP_ALUI) ||
                   (opcode == OP_JALR) || (opcode == OP_SYSTEM);
  assign is_s    = (opcode == OP_STORE);
  assign is_b    = (opcode == OP_BRANCH);
  assign is_u    = (opcode == OP_LUI) || (opcode == OP_AUIPC);
  assign is_j    = (opcode == OP_JAL);
  assign is_r    = (opcode == OP_ALUR);
  assign is_alui = (opcode == OP_ALUI);

  // ---------------- immediate decoder ----------------
  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_i: imm = {{20{instr[31]}}, instr[31:20]};
      is_s: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      is_b: imm = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
      is_u: imm = {instr[31:12], 12'b0};
      is_j: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // ---------------- ALU ----------------
  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  sh;
  logic        lt_s;
  logic        lt_u;
  logic        eq;

  assign sum  = in_a + in_b;
  assign diff = in_a - in_b;
  assign sh   = in_b[4:0];
  assign lt_s = $signed(in_a) < $signed(in_b);
  assign lt_u = in_a < in_b;
  assign eq   = (in_a == in_b);

  // Non-ALU opcodes fall through to a plain add (link, AUIPC, addresses).
  always_comb begin
    result = sum;
    if (is_r || is_alui) begin
      unique case (f3)
        3'b000:  result = (is_r && alt) ? diff : sum;
        3'b001:  result = in_a << sh;
        3'b010:  result = {31'b0, lt_s};
        3'b011:  result = {31'b0, lt_u};
        3'b100:  result = in_a ^ in_b;
        3'b101:  result = alt ? 32'($signed(in_a) >>> sh) : (in_a >> sh);
        3'b110:  result = in_a | in_b;
        3'b111:  result = in_a & in_b;
        default: result = sum;
      endcase
    end
  end

  // ---------------- branch compare ----------------
  always_comb begin
    take_b = 1'b0;
    if (is_b) begin
      unique case (f3)
        3'b000:  take_b = eq;
        3'b001:  take_b = !eq;
        3'b100:  take_b = lt_s;
        3'b101:  take_b = !lt_s;
        3'b110:  take_b = lt_u;
        3'b111:  take_b = !lt_u;
        default: take_b = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_exec_datapath.sv
// Scoreboard bench for rv32i_exec_datapath: directed vectors,
// expectations queued by the driver and checked by a monitor.
module tb_rv32i_exec_datapath;

  logic        CLK;
  logic        RESET;
  logic        clk;
  logic        resetn;
  logic [31:0] instr;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] imm;
  logic [31:0] result;
  logic        take_b;

  rv32i_exec_datapath #(.RESET_CYCLES(16)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .clk    (clk),
    .resetn (resetn),
    .instr  (instr),
    .in_a   (in_a),
    .in_b   (in_b),
    .imm    (imm),
    .result (result),
    .take_b (take_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] imm;
    logic [31:0] res;
    logic        tk;
    logic        rn;
    bit          c_alu;
    bit          c_rn;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string f,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  // Monitor: one expectation consumed per falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.c_alu) begin
        chk(e.name, "imm", imm, e.imm);
        chk(e.name, "result", result, e.res);
        chk(e.name, "take_b", {31'b0, take_b}, {31'b0, e.tk});
      end
      if (e.c_rn)
        chk(e.name, "resetn", {31'b0, resetn}, {31'b0, e.rn});
      chk(e.name, "clk", {31'b0, clk}, 32'd0);
    end
  end

  // Drive RESET for one edge, expect resetn after that edge.
  task automatic rst_edge(input string nm, input logic r, input logic rn);
    exp_t e;
    RESET = r;
    @(posedge CLK);
    #1;
    e.name = nm; e.imm = '0; e.res = '0; e.tk = 1'b0;
    e.rn = rn; e.c_alu = 1'b0; e.c_rn = 1'b1;
    q.push_back(e);
  endtask

  task automatic alu(input string nm, input logic [31:0] ins,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ei, input logic [31:0] er,
                     input logic et);
    exp_t e;
    @(posedge CLK);
    #1;
    instr = ins; in_a = a; in_b = b;
    e.name = nm; e.imm = ei; e.res = er; e.tk = et;
    e.rn = 1'b0; e.c_alu = 1'b1; e.c_rn = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    RESET = 1'b1;
    instr = '0;
    in_a  = '0;
    in_b  = '0;

    // reset held 3 edges, then release: low through edge 15, high at 16
    for (int i = 0; i < 3; i++) rst_edge("rst_hold", 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++)
      rst_edge($sformatf("rel_e%0d", k), 1'b0, (k >= 16));
    rst_edge("rst_stay", 1'b0, 1'b1);

    // one-edge pulse, then reassert at edge 8 to restart the count
    rst_edge("pulse", 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++)
      rst_edge($sformatf("pre_e%0d", k), 1'b0, 1'b0);
    rst_edge("reassert", 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++)
      rst_edge($sformatf("re_e%0d", k), 1'b0, (k >= 16));

    alu("add",   32'h00000033, 32'd5, 32'd7, 32'h0, 32'd12, 1'b0);
    alu("sub",   32'h40000033, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFE, 1'b0);
    alu("addi",  32'hFFF00093, 32'd5, 32'hFFFFFFFF,
        32'hFFFFFFFF, 32'd4, 1'b0);
    alu("sra",   32'h40005033, 32'h80000000, 32'd4, 32'h0, 32'hF8000000, 1'b0);
    alu("srl",   32'h00005033, 32'h80000000, 32'd4, 32'h0, 32'h08000000, 1'b0);
    alu("sll",   32'h00001033, 32'h80000000, 32'd4, 32'h0, 32'h0, 1'b0);
    alu("srai",  32'h40405013, 32'h80000000, 32'd4,
        32'h00000404, 32'hF8000000, 1'b0);
    alu("slt",   32'h00002033, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd1, 1'b0);
    alu("sltu",  32'h00003033, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd0, 1'b0);
    alu("xor",   32'h00004033, 32'hF0F01234, 32'h0FF000FF,
        32'h0, 32'hFF0012CB, 1'b0);
    alu("or",    32'h00006033, 32'hF0F01234, 32'h0FF000FF,
        32'h0, 32'hFFF012FF, 1'b0);
    alu("and",   32'h00007033, 32'hF0F01234, 32'h0FF000FF,
        32'h0, 32'h00F00034, 1'b0);

    alu("beq",   32'h00000063, 32'd3, 32'd3, 32'h0, 32'd6, 1'b1);
    alu("bne",   32'h00001063, 32'd3, 32'd3, 32'h0, 32'd6, 1'b0);
    alu("blt",   32'h00004063, 32'hFFFFFFFF, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b1);
    alu("bge",   32'h00005063, 32'hFFFFFFFF, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b0);
    alu("bltu",  32'h00006063, 32'hFFFFFFFF, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b0);
    alu("bgeu",  32'h00007063, 32'hFFFFFFFF, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b1);
    alu("b_f3_2", 32'h00002063, 32'd3, 32'd3, 32'h0, 32'd6, 1'b0);
    alu("nonbr_eq", 32'h00000033, 32'd3, 32'd3, 32'h0, 32'd6, 1'b0);

    alu("imm_s", 32'hFE112E23, 32'h10, 32'hFFFFFFFC,
        32'hFFFFFFFC, 32'h0000000C, 1'b0);
    alu("imm_b", 32'hFE000EE3, 32'd1, 32'd2, 32'hFFFFFFFC, 32'd3, 1'b0);
    alu("lui",   32'h123450B7, 32'h0, 32'h12345000,
        32'h12345000, 32'h12345000, 1'b0);
    alu("jal",   32'h0080006F, 32'h100, 32'd4, 32'd8, 32'h104, 1'b0);
    alu("auipc", 32'h00001017, 32'h100, 32'h1000,
        32'h00001000, 32'h1100, 1'b0);
    alu("wrap",  32'h00000003, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0);
    alu("jalr",  32'h80000067, 32'h200, 32'd4, 32'hFFFFF800, 32'h204, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
